// File: rtl/shift_register_universal.sv
`default_nettype none
// ============================================================================
// Module   : shift_register_universal
// Brief    : Parametrised universal shift register with shift, rotate,
//            parallel load and clear, a registered serial output and a
//            per-word shift counter that pulses word_done on completion.
// Revision : 1.0 - initial release
// ============================================================================
module shift_register_universal #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 mode,
    input  logic                       data_in,
    input  logic [WIDTH-1:0]           parallel_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       serial_out,
    output logic [$clog2(WIDTH)-1:0]   shift_count,
    output logic                       word_done
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] c_mode_hold  = 3'b000;
    localparam logic [2:0] c_mode_shl   = 3'b001;
    localparam logic [2:0] c_mode_shr   = 3'b010;
    localparam logic [2:0] c_mode_rotl  = 3'b011;
    localparam logic [2:0] c_mode_rotr  = 3'b100;
    localparam logic [2:0] c_mode_load  = 3'b101;
    localparam logic [2:0] c_mode_clear = 3'b110;

    // Count value at which the next counting operation completes a word.
    localparam logic [CW-1:0] c_last_count = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_data;
    logic             r_serial;
    logic [CW-1:0]    r_count;
    logic             r_word_done;

    logic             w_counting;
    logic             w_wrap;

    // Shifts and rotates both advance the word counter, regardless of direction.
    always_comb begin
        w_counting = (mode == c_mode_shl)  || (mode == c_mode_shr) ||
                     (mode == c_mode_rotl) || (mode == c_mode_rotr);
        w_wrap     = (r_count == c_last_count);
    end

    // Register update: reset wins over every mode; hold and reserved keep state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data      <= RESET_VALUE;
            r_serial    <= 1'b0;
            r_count     <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            if (w_counting) begin
                if (w_wrap) begin
                    r_count     <= '0;
                    r_word_done <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
            case (mode)
                c_mode_shl: begin
                    r_data   <= {r_data[WIDTH-2:0], data_in};
                    r_serial <= r_data[WIDTH-1];
                end
                c_mode_shr: begin
                    r_data   <= {data_in, r_data[WIDTH-1:1]};
                    r_serial <= r_data[0];
                end
                c_mode_rotl: begin
                    r_data   <= {r_data[WIDTH-2:0], r_data[WIDTH-1]};
                    r_serial <= r_data[WIDTH-1];
                end
                c_mode_rotr: begin
                    r_data   <= {r_data[0], r_data[WIDTH-1:1]};
                    r_serial <= r_data[0];
                end
                c_mode_load: begin
                    r_data   <= parallel_in;
                    r_serial <= 1'b0;
                    r_count  <= '0;
                end
                c_mode_clear: begin
                    r_data   <= '0;
                    r_serial <= 1'b0;
                    r_count  <= '0;
                end
                c_mode_hold: begin
                    r_data <= r_data;
                end
                default: begin
                    r_data <= r_data;
                end
            endcase
        end
    end

    assign data_out    = r_data;
    assign serial_out  = r_serial;
    assign shift_count = r_count;
    assign word_done   = r_word_done;

endmodule
`default_nettype wire
